// File: rtl/buf_cache_ctrl.sv
// Requester-side controller for a 4-entry buffer pool.
// It compares each lookup tag against four tag registers. A hit reports the
// buffer and sends an LFU reference. A miss fills the lowest free buffer, or
// the LFU victim when the pool is full, and then responds.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a lookup; inv_all clears the pool here
// LOOKUP   | latched tag compared against valid entries
// LFU_REQ  | one-cycle replacement request to the LFU finder
// LFU_WAIT | LFU victim captured as the fill destination
// FILL     | fill handshake with the backing store
// RESP     | response held until the consumer accepts it
module buf_cache_ctrl #(
  parameter int TAG_W = 8,
  parameter int LEN   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_rdy,
  input  logic             inv_all,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic             rsp_hit,
  output logic [LEN-1:0]   rsp_buf,
  output logic             lfu_req,
  input  logic [LEN-1:0]   lfu_victim,
  output logic [LEN-1:0]   lfu_ref,
  output logic             lfu_ref_vld,
  output logic             fill_req,
  output logic [TAG_W-1:0] fill_tag,
  output logic [LEN-1:0]   fill_buf,
  input  logic             fill_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {IDLE, LOOKUP, LFU_REQ, LFU_WAIT, FILL, RESP} state_t;

  state_t           state;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] tag_mem [4];
  logic [3:0]       valid;
  logic             hit;
  logic [LEN-1:0]   hit_idx;
  logic             free;
  logic [LEN-1:0]   free_idx;

  // Handshake and strobe outputs decode directly from the state.
  assign req_rdy  = (state == IDLE) & ~inv_all;
  assign rsp_vld  = (state == RESP);
  assign lfu_req  = (state == LFU_REQ);
  assign fill_req = (state == FILL);

  // Tag match and lowest free entry; scanning downward makes index 0 win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (valid[i] && (tag_mem[i] == tag_q)) begin
        hit     = 1'b1;
        hit_idx = LEN'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = LEN'(i);
      end
    end
  end

  // Tag storage is written only when a fill completes and needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == FILL) && fill_ack)
      tag_mem[fill_buf] <= fill_tag;
  end

  // Main controller FSM with registered response, fill, LFU and counter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      tag_q       <= '0;
      rsp_hit     <= 1'b0;
      rsp_buf     <= '0;
      lfu_ref     <= '0;
      lfu_ref_vld <= 1'b0;
      fill_tag    <= '0;
      fill_buf    <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      lfu_ref_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (inv_all) begin
            valid <= '0;
          end else if (req_vld) begin
            tag_q <= req_tag;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rsp_hit     <= 1'b1;
            rsp_buf     <= hit_idx;
            lfu_ref     <= hit_idx;
            lfu_ref_vld <= 1'b1;
            state       <= RESP;
          end else begin
            fill_tag <= tag_q;
            if (free) begin
              fill_buf <= free_idx;
              state    <= FILL;
            end else begin
              state <= LFU_REQ;
            end
          end
        end
        LFU_REQ: state <= LFU_WAIT;
        LFU_WAIT: begin
          fill_buf <= lfu_victim;
          state    <= FILL;
        end
        FILL: begin
          if (fill_ack) begin
            valid[fill_buf] <= 1'b1;
            rsp_hit         <= 1'b0;
            rsp_buf         <= fill_buf;
            state           <= RESP;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            state <= IDLE;
            if (rsp_hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_cache_ctrl.sv
// Bench for buf_cache_ctrl: directed scenarios plus random lookups checked
// against a tag-pool model. Inputs change and outputs are sampled on negedge.
module tb_buf_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_vld = 1'b0;
  logic [7:0] req_tag = '0;
  logic       req_rdy;
  logic       inv_all = 1'b0;
  logic       rsp_vld;
  logic       rsp_rdy = 1'b0;
  logic       rsp_hit;
  logic [1:0] rsp_buf;
  logic       lfu_req;
  logic [1:0] lfu_victim = '0;
  logic [1:0] lfu_ref;
  logic       lfu_ref_vld;
  logic       fill_req;
  logic [7:0] fill_tag;
  logic [1:0] fill_buf;
  logic       fill_ack = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  buf_cache_ctrl dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_tag(req_tag), .req_rdy(req_rdy),
    .inv_all(inv_all), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit),
    .rsp_buf(rsp_buf), .lfu_req(lfu_req), .lfu_victim(lfu_victim), .lfu_ref(lfu_ref),
    .lfu_ref_vld(lfu_ref_vld), .fill_req(fill_req), .fill_tag(fill_tag),
    .fill_buf(fill_buf), .fill_ack(fill_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pool contents and statistics.
  logic [7:0]  mdl_tag [4];
  logic [3:0]  mdl_vld;
  logic [15:0] mdl_hits;
  logic [15:0] mdl_miss;

  // Observations of the latest transaction (cycle numbers relative to accept).
  int         ob_timeout, ob_wait, ob_lfu_cnt, ob_lfu_cyc, ob_fill_cyc, ob_ack_cyc;
  int         ob_rsp_cyc, ob_rsp_cnt, ob_ref_cnt;
  bit         ob_unstable, ob_rdy_busy, ob_fill_late;
  logic       ob_hit;
  logic [1:0] ob_buf, ob_ref, ob_fill_buf;
  logic [7:0] ob_fill_tag;

  task automatic model_reset();
    mdl_vld  = '0;
    mdl_hits = '0;
    mdl_miss = '0;
    for (int i = 0; i < 4; i++) mdl_tag[i] = '0;
  endtask

  task automatic model_txn(input logic [7:0] tag, input logic [1:0] victim,
                           output logic hit, output logic [1:0] b, output logic full);
    int f;
    hit  = 1'b0;
    b    = '0;
    full = &mdl_vld;
    for (int i = 0; i < 4; i++)
      if (mdl_vld[i] && mdl_tag[i] == tag) begin hit = 1'b1; b = 2'(i); end
    if (hit) begin
      if (mdl_hits != 16'hFFFF) mdl_hits++;
    end else begin
      f = -1;
      for (int i = 3; i >= 0; i--) if (!mdl_vld[i]) f = i;
      b = (f >= 0) ? 2'(f) : victim;
      mdl_tag[b] = tag;
      mdl_vld[b] = 1'b1;
      if (mdl_miss != 16'hFFFF) mdl_miss++;
    end
  endtask

  // Runs one lookup from a negedge in IDLE to the negedge after the response handshake.
  task automatic drive_txn(input logic [7:0] tag, input logic [1:0] victim,
                           input int ack_dly, input int rdy_dly);
    int  n;
    bit  done;
    ob_timeout = 0; ob_wait = 0; ob_lfu_cnt = 0; ob_lfu_cyc = -1; ob_fill_cyc = -1;
    ob_ack_cyc = -1; ob_rsp_cyc = -1; ob_rsp_cnt = 0; ob_ref_cnt = 0;
    ob_unstable = 0; ob_rdy_busy = 0; ob_fill_late = 0;
    ob_hit = 1'bx; ob_buf = 'x; ob_ref = 'x; ob_fill_buf = 'x; ob_fill_tag = 'x;
    req_vld = 1'b1; req_tag = tag; lfu_victim = victim;
    #1;
    while (!req_rdy && ob_wait < 20) begin @(negedge clk); #1; ob_wait++; end
    if (!req_rdy) begin ob_timeout = 1; req_vld = 1'b0; return; end
    n = 0; done = 0;
    while (!done && n < 80) begin
      @(negedge clk); n++;
      req_vld = 1'b0;
      if (req_rdy) ob_rdy_busy = 1;
      if (lfu_req) begin ob_lfu_cnt++; ob_lfu_cyc = n; end
      if (lfu_ref_vld) begin ob_ref_cnt++; ob_ref = lfu_ref; end
      if (fill_req) begin
        if (ob_fill_cyc < 0) begin
          ob_fill_cyc = n; ob_fill_tag = fill_tag; ob_fill_buf = fill_buf;
        end else if (fill_tag !== ob_fill_tag || fill_buf !== ob_fill_buf) ob_unstable = 1;
        if (ob_ack_cyc >= 0) ob_fill_late = 1;
        else if (n >= ob_fill_cyc + ack_dly) begin fill_ack = 1'b1; ob_ack_cyc = n; end
      end else fill_ack = 1'b0;
      if (rsp_vld) begin
        ob_rsp_cnt++;
        if (ob_rsp_cyc < 0) begin ob_rsp_cyc = n; ob_hit = rsp_hit; ob_buf = rsp_buf; end
        else if (rsp_hit !== ob_hit || rsp_buf !== ob_buf) ob_unstable = 1;
        if (n >= ob_rsp_cyc + rdy_dly) begin rsp_rdy = 1'b1; done = 1; end
      end
    end
    if (!done) ob_timeout = 1;
    @(negedge clk);
    rsp_rdy = 1'b0; fill_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_vld = 1'b0; inv_all = 1'b0; rsp_rdy = 1'b0; fill_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL reset_req_rdy got=%b want=1", req_rdy); end
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL reset_rsp_vld got=%b want=0", rsp_vld); end
    total++; if (fill_req !== 1'b0 || lfu_req !== 1'b0 || lfu_ref_vld !== 1'b0) begin bad++;
      $display("FAIL reset_strobes got fill=%b lfu=%b ref=%b want 0", fill_req, lfu_req, lfu_ref_vld); end
    total++; if ({rsp_hit, rsp_buf, lfu_ref, fill_tag, fill_buf} !== '0) begin bad++;
      $display("FAIL reset_regs got hit=%b buf=%0d ref=%0d ftag=%h fbuf=%0d want 0", rsp_hit, rsp_buf, lfu_ref, fill_tag, fill_buf); end
    total++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin bad++;
      $display("FAIL reset_cnt got hit=%0d miss=%0d want 0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_fill_order();
    logic h, f; logic [1:0] b;
    for (int i = 0; i < 4; i++) begin
      model_txn(8'h10 * (i + 1), 2'd0, h, b, f);
      drive_txn(8'h10 * (i + 1), 2'd0, 0, 0);
      total++; if (ob_timeout != 0) begin bad++; $display("FAIL fill_timeout idx=%0d", i); end
      total++; if (ob_fill_buf !== 2'(i) || ob_fill_cyc != 2) begin bad++;
        $display("FAIL fill_order got buf=%0d cyc=%0d want buf=%0d cyc=2", ob_fill_buf, ob_fill_cyc, i); end
      total++; if (ob_lfu_cnt != 0 || ob_hit !== 1'b0 || ob_buf !== 2'(i)) begin bad++;
        $display("FAIL fill_rsp got lfu=%0d hit=%b buf=%0d want 0/0/%0d", ob_lfu_cnt, ob_hit, ob_buf, i); end
      total++; if (ob_rsp_cyc != ob_ack_cyc + 1) begin bad++;
        $display("FAIL fill_rsp_lat got=%0d want=%0d", ob_rsp_cyc, ob_ack_cyc + 1); end
    end
    total++; if (miss_cnt !== 16'd4) begin bad++; $display("FAIL fill_miss_cnt got=%0d want=4", miss_cnt); end
  endtask

  task automatic test_hit();
    logic h, f; logic [1:0] b;
    model_txn(8'h30, 2'd0, h, b, f);
    drive_txn(8'h30, 2'd0, 0, 0);
    total++; if (ob_rsp_cyc != 2 || ob_hit !== 1'b1 || ob_buf !== 2'd2) begin bad++;
      $display("FAIL hit_rsp got cyc=%0d hit=%b buf=%0d want 2/1/2", ob_rsp_cyc, ob_hit, ob_buf); end
    total++; if (ob_ref_cnt != 1 || ob_ref !== 2'd2) begin bad++;
      $display("FAIL hit_ref got cnt=%0d ref=%0d want 1/2", ob_ref_cnt, ob_ref); end
    total++; if (hit_cnt !== 16'd1 || ob_fill_cyc != -1) begin bad++;
      $display("FAIL hit_cnt got=%0d fill_cyc=%0d want 1/-1", hit_cnt, ob_fill_cyc); end
  endtask

  task automatic test_lfu_replace();
    logic h, f; logic [1:0] b;
    model_txn(8'h50, 2'd1, h, b, f);
    drive_txn(8'h50, 2'd1, 1, 0);
    total++; if (ob_lfu_cnt != 1 || ob_lfu_cyc != 2 || ob_fill_cyc != 4) begin bad++;
      $display("FAIL lfu_lat got n=%0d lfu=%0d fill=%0d want 1/2/4", ob_lfu_cnt, ob_lfu_cyc, ob_fill_cyc); end
    total++; if (ob_fill_buf !== 2'd1 || ob_fill_tag !== 8'h50 || ob_buf !== 2'd1) begin bad++;
      $display("FAIL lfu_fill got buf=%0d tag=%h rbuf=%0d want 1/50/1", ob_fill_buf, ob_fill_tag, ob_buf); end
    model_txn(8'h20, 2'd0, h, b, f);
    drive_txn(8'h20, 2'd0, 0, 0);
    total++; if (ob_hit !== 1'b0 || ob_buf !== 2'd0 || ob_lfu_cnt != 1) begin bad++;
      $display("FAIL lfu_evicted got hit=%b buf=%0d lfu=%0d want 0/0/1", ob_hit, ob_buf, ob_lfu_cnt); end
    model_txn(8'h50, 2'd3, h, b, f);
    drive_txn(8'h50, 2'd3, 0, 0);
    total++; if (ob_hit !== 1'b1 || ob_buf !== 2'd1 || ob_rsp_cyc != 2) begin bad++;
      $display("FAIL lfu_rehit got hit=%b buf=%0d cyc=%0d want 1/1/2", ob_hit, ob_buf, ob_rsp_cyc); end
  endtask

  task automatic test_backpressure();
    logic h, f; logic [1:0] b;
    model_txn(8'h30, 2'd0, h, b, f);
    drive_txn(8'h30, 2'd0, 0, 5);
    total++; if (ob_rsp_cnt != 6 || ob_unstable) begin bad++;
      $display("FAIL bp_hold got rsp_cycles=%0d unstable=%0d want 6/0", ob_rsp_cnt, ob_unstable); end
    total++; if (ob_ref_cnt != 1 || ob_rdy_busy) begin bad++;
      $display("FAIL bp_ref got refs=%0d rdy_busy=%0d want 1/0", ob_ref_cnt, ob_rdy_busy); end
    total++; if (ob_hit !== h || ob_buf !== b) begin bad++;
      $display("FAIL bp_rsp got hit=%b buf=%0d want %b/%0d", ob_hit, ob_buf, h, b); end
  endtask

  task automatic test_inv_all();
    logic h, f; logic [1:0] b;
    inv_all = 1'b1; req_vld = 1'b1; req_tag = 8'h30;
    #1;
    total++; if (req_rdy !== 1'b0) begin bad++; $display("FAIL inv_rdy got=%b want=0", req_rdy); end
    @(negedge clk);
    inv_all = 1'b0;
    mdl_vld = '0;
    model_txn(8'h30, 2'd2, h, b, f);
    drive_txn(8'h30, 2'd2, 2, 0);
    total++; if (ob_wait != 0 || ob_hit !== 1'b0 || ob_fill_buf !== 2'd0) begin bad++;
      $display("FAIL inv_miss got wait=%0d hit=%b fbuf=%0d want 0/0/0", ob_wait, ob_hit, ob_fill_buf); end
    total++; if (ob_rsp_cyc != ob_ack_cyc + 1 || ob_fill_late) begin bad++;
      $display("FAIL inv_ack_lat got rsp=%0d ack=%0d late=%0d", ob_rsp_cyc, ob_ack_cyc, ob_fill_late); end
  endtask

  task automatic test_reset_mid_fill();
    logic h, f; logic [1:0] b;
    int rsp_seen;
    req_vld = 1'b1; req_tag = 8'hA5; #1;
    total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL rmf_accept got=%b want=1", req_rdy); end
    @(negedge clk); req_vld = 1'b0;
    @(negedge clk);
    total++; if (fill_req !== 1'b1) begin bad++; $display("FAIL rmf_fill got=%b want=1", fill_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (fill_req !== 1'b0) begin bad++; $display("FAIL rmf_drop got=%b want=0", fill_req); end
    total++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin bad++;
      $display("FAIL rmf_cnt got hit=%0d miss=%0d want 0", hit_cnt, miss_cnt); end
    rsp_seen = 0;
    repeat (5) begin if (rsp_vld || fill_req) rsp_seen++; @(negedge clk); end
    total++; if (rsp_seen != 0) begin bad++; $display("FAIL rmf_no_rsp got=%0d want=0", rsp_seen); end
    model_reset();
    model_txn(8'h77, 2'd3, h, b, f);
    drive_txn(8'h77, 2'd3, 0, 0);
    total++; if (ob_hit !== 1'b0 || ob_fill_buf !== 2'd0 || ob_fill_cyc != 2) begin bad++;
      $display("FAIL rmf_next got hit=%b fbuf=%0d cyc=%0d want 0/0/2", ob_hit, ob_fill_buf, ob_fill_cyc); end
  endtask

  task automatic test_random();
    logic h, f; logic [1:0] b, v;
    logic [7:0] t;
    int ad, rd;
    apply_reset();
    for (int k = 0; k < 60; k++) begin
      t  = 8'($urandom_range(0, 6)) + 8'h80;
      v  = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      model_txn(t, v, h, b, f);
      drive_txn(t, v, ad, rd);
      total++; if (ob_timeout != 0 || ob_wait != 0) begin bad++;
        $display("FAIL rnd_flow k=%0d timeout=%0d wait=%0d", k, ob_timeout, ob_wait); end
      total++; if (ob_hit !== h || ob_buf !== b) begin bad++;
        $display("FAIL rnd_rsp k=%0d tag=%h got hit=%b buf=%0d want %b/%0d", k, t, ob_hit, ob_buf, h, b); end
      total++; if (ob_unstable || ob_rdy_busy || ob_fill_late || ob_rsp_cnt != rd + 1) begin bad++;
        $display("FAIL rnd_proto k=%0d unst=%0d busy=%0d late=%0d rsp_cycles=%0d want %0d", k, ob_unstable, ob_rdy_busy, ob_fill_late, ob_rsp_cnt, rd + 1); end
      if (h) begin
        total++; if (ob_rsp_cyc != 2 || ob_ref_cnt != 1 || ob_ref !== b || ob_fill_cyc != -1 || ob_lfu_cnt != 0) begin bad++;
          $display("FAIL rnd_hit k=%0d cyc=%0d refs=%0d ref=%0d fill=%0d lfu=%0d want 2/1/%0d/-1/0", k, ob_rsp_cyc, ob_ref_cnt, ob_ref, ob_fill_cyc, ob_lfu_cnt, b); end
      end else begin
        total++; if (ob_fill_buf !== b || ob_fill_tag !== t || ob_ref_cnt != 0 || ob_rsp_cyc != ob_ack_cyc + 1) begin bad++;
          $display("FAIL rnd_miss k=%0d fbuf=%0d ftag=%h refs=%0d rsp=%0d ack=%0d want buf=%0d tag=%h", k, ob_fill_buf, ob_fill_tag, ob_ref_cnt, ob_rsp_cyc, ob_ack_cyc, b, t); end
        total++; if (ob_fill_cyc != (f ? 4 : 2) || ob_lfu_cnt != (f ? 1 : 0) || (f && ob_lfu_cyc != 2)) begin bad++;
          $display("FAIL rnd_miss_lat k=%0d fill=%0d lfu=%0d lfu_cyc=%0d full=%b", k, ob_fill_cyc, ob_lfu_cnt, ob_lfu_cyc, f); end
      end
      total++; if (hit_cnt !== mdl_hits || miss_cnt !== mdl_miss) begin bad++;
        $display("FAIL rnd_cnt k=%0d got hit=%0d miss=%0d want %0d/%0d", k, hit_cnt, miss_cnt, mdl_hits, mdl_miss); end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill_order();
    test_hit();
    test_lfu_replace();
    test_backpressure();
    test_inv_all();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buf_cache_ctrl.md
Name: buf_cache_ctrl

Overview:
- Requester-side controller for a 4-entry buffer pool. It drives the lfu_finder interface: a one-cycle replacement request, plus buffer references on hits.
- Accepts tag lookups over a valid/ready handshake and compares them against 4 tag registers.
- On a hit, reports the buffer and issues an LFU reference. On a miss, fills a free buffer or the LFU victim through a fill handshake, then responds.

Parameters:
- TAG_W, 8, lookup tag width
- LEN, 2, buffer-number width (pool fixed at 4 entries)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_vld  in  1  lookup request valid
- req_tag  in  TAG_W  lookup tag
- req_rdy  out  1  controller can accept a request
- inv_all  in  1  single-cycle pulse; invalidate all entries
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response consumer ready
- rsp_hit  out  1  1 = hit, 0 = miss (filled)
- rsp_buf  out  LEN  buffer number holding the tag
- lfu_req  out  1  replacement request to the LFU finder (one-cycle pulse)
- lfu_victim  in  LEN  LFU-selected buffer; valid the cycle after lfu_req
- lfu_ref  out  LEN  referenced buffer number
- lfu_ref_vld  out  1  lfu_ref qualifier (one-cycle pulse)
- fill_req  out  1  fill request to backing store
- fill_tag  out  TAG_W  tag being filled
- fill_buf  out  LEN  destination buffer
- fill_ack  in  1  fill complete
- hit_cnt  out  CNT_W  hit count, saturating
- miss_cnt  out  CNT_W  miss count, saturating

Behaviour:
- State machine states: IDLE, LOOKUP, LFU_REQ, LFU_WAIT, FILL, RESP. All outputs are registered or decoded from state.
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; all 4 valid bits clear.
  - All outputs are 0: rsp_buf=0, lfu_ref=0, fill_tag=0, fill_buf=0, hit_cnt=0, miss_cnt=0.
  - Reset mid-operation (any state) aborts the operation: fill_req drops the next cycle and no response is issued.
- IDLE:
  - req_rdy = (state==IDLE) & ~inv_all.
  - inv_all=1 clears all valid bits and blocks acceptance that cycle (inv_all has priority over req_vld).
  - inv_all is ignored outside IDLE.
  - On req_vld & req_rdy: latch req_tag, go to LOOKUP.
- LOOKUP (1 cycle): compare the latched tag against valid entries 0..3.
  - Hit at entry i: rsp_hit=1, rsp_buf=i, go to RESP.
  - Miss with any invalid entry: fill_buf = lowest invalid index, go to FILL. The LFU is not consulted.
  - Miss with all entries valid: go to LFU_REQ.
- LFU_REQ: lfu_req=1 for exactly this cycle, then go to LFU_WAIT.
- LFU_WAIT: capture lfu_victim into fill_buf, go to FILL.
- FILL:
  - fill_req=1 with stable fill_tag and fill_buf.
  - fill_ack is sampled every FILL cycle, including the first one.
  - On ack: write tag[fill_buf]=tag, set valid[fill_buf]=1, rsp_hit=0, rsp_buf=fill_buf, go to RESP.
  - fill_req deasserts in the cycle after ack.
- RESP:
  - rsp_vld=1; rsp_hit and rsp_buf are held stable until rsp_rdy.
  - On rsp_vld & rsp_rdy: go to IDLE; increment hit_cnt if hit, else miss_cnt.
  - Counters saturate at all-ones.
  - On a hit, lfu_ref=rsp_buf and lfu_ref_vld=1 for only the first RESP cycle, regardless of backpressure.
  - Misses issue no lfu_ref_vld.
- Latency, request accepted at cycle T:
  - Hit: rsp_vld at T+2.
  - Miss to a free entry: fill_req at T+2.
  - Miss with full pool: lfu_req at T+2, fill_req at T+4.
  - Miss with fill_ack arriving at cycle A: rsp_vld at A+1.
  - With rsp_rdy=1, the next request is accepted one cycle after the response handshake.
- Ordering and duplicates:
  - One outstanding request at a time; no reordering.
  - Duplicate tags cannot occur, because fill occurs only on a miss.

Test Plan:
- Reset, then tags 0x10, 0x20, 0x30, 0x40 with immediate fill_ack → fill_buf 0, 1, 2, 3 in order; lfu_req never asserted; miss_cnt=4.
- Tag 0x30 after that fill → rsp_vld at T+2 with rsp_hit=1, rsp_buf=2; lfu_ref=2 with lfu_ref_vld high 1 cycle; hit_cnt=1.
- Tag 0x50 with pool full, lfu_victim=1 → lfu_req at T+2; fill_buf=1 and fill_tag=0x50 at T+4; later tag 0x20 misses and tag 0x50 hits at rsp_buf=1.
- Hit with rsp_rdy held low 5 cycles → rsp_vld and rsp_buf stable for 6 cycles; lfu_ref_vld pulses once; req_rdy stays 0 until the handshake.
- inv_all and req_vld together in IDLE → req_rdy=0 that cycle; request accepted the next cycle and misses with fill_buf=0.
- rst asserted during FILL (fill_ack held 0) → fill_req=0 the next cycle; no rsp_vld; counters 0; the next request misses into fill_buf=0.
